// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one memory port between IFU and LSU, one transaction outstanding
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LSU_PRIORITY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_resp_err,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp_err,
  output logic                busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic               last_grant;  // 1 = LSU
  logic               owner;       // 1 = LSU
  logic [CNT_W-1:0]   counter;

  logic               grant_lsu;
  logic               grant_ifu;
  logic               timeout_hit;
  logic               wait_done;
  logic [DATA_W-1:0]  done_data;
  logic               done_err;

  always_comb begin
    grant_lsu = lsu_req_valid &&
                (!ifu_req_valid || (LSU_PRIORITY != 0) || !last_grant);
    grant_ifu = ifu_req_valid && !grant_lsu;
  end

  // A timeout completes the transaction like an error response with no data.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (counter == CNT_LAST);
    wait_done   = mem_resp_valid || timeout_hit;
    done_data   = (mem_resp_valid && !mem_wen) ? mem_rdata : '0;
    done_err    = mem_resp_valid ? mem_resp_err : 1'b1;
  end

  assign ifu_req_ready = (state == IDLE) && !rst && grant_ifu;
  assign lsu_req_ready = (state == IDLE) && !rst && grant_lsu;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      last_grant     <= 1'b0;
      owner          <= 1'b0;
      counter        <= '0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
      ifu_resp_valid <= 1'b0;
      ifu_rdata      <= '0;
      ifu_resp_err   <= 1'b0;
      lsu_resp_valid <= 1'b0;
      lsu_rdata      <= '0;
      lsu_resp_err   <= 1'b0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_lsu) begin
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            owner         <= 1'b1;
            last_grant    <= 1'b1;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end else if (grant_ifu) begin
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            owner         <= 1'b0;
            last_grant    <= 1'b0;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            counter       <= '0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (wait_done) begin
            if (owner) begin
              lsu_resp_valid <= 1'b1;
              lsu_rdata      <= done_data;
              lsu_resp_err   <= done_err;
            end else begin
              ifu_resp_valid <= 1'b1;
              ifu_rdata      <= done_data;
              ifu_resp_err   <= done_err;
            end
            state <= RESP;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, lsu_req_valid, lsu_wen;
  logic [31:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_ready, mem_resp_valid, mem_resp_err;

  // dut a: LSU priority; dut b: round-robin. Both share all inputs.
  logic        a_ifu_req_ready, a_ifu_resp_valid, a_ifu_resp_err;
  logic        a_lsu_req_ready, a_lsu_resp_valid, a_lsu_resp_err;
  logic [31:0] a_ifu_rdata, a_lsu_rdata, a_mem_addr, a_mem_wdata;
  logic        a_mem_req_valid, a_mem_wen, a_busy;
  logic [3:0]  a_mem_wmask;
  logic        b_ifu_req_ready, b_ifu_resp_valid, b_ifu_resp_err;
  logic        b_lsu_req_ready, b_lsu_resp_valid, b_lsu_resp_err;
  logic [31:0] b_ifu_rdata, b_lsu_rdata, b_mem_addr, b_mem_wdata;
  logic        b_mem_req_valid, b_mem_wen, b_busy;
  logic [3:0]  b_mem_wmask;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIORITY(1), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(a_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(a_ifu_resp_valid), .ifu_rdata(a_ifu_rdata), .ifu_resp_err(a_ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(a_lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(a_lsu_resp_valid), .lsu_rdata(a_lsu_rdata), .lsu_resp_err(a_lsu_resp_err),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(a_mem_addr),
    .mem_wen(a_mem_wen), .mem_wdata(a_mem_wdata), .mem_wmask(a_mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .busy(a_busy)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIORITY(0), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(b_ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(b_ifu_resp_valid), .ifu_rdata(b_ifu_rdata), .ifu_resp_err(b_ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(b_lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(b_lsu_resp_valid), .lsu_rdata(b_lsu_rdata), .lsu_resp_err(b_lsu_resp_err),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(b_mem_addr),
    .mem_wen(b_mem_wen), .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err),
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    string grants;
    int    last_cyc;
    int    a_ifu_grants;

    rst = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
    step();
    step();
    // reset state, with a request pending that must not be accepted
    check("rst_busy", a_busy, 0);
    check("rst_ready", {a_ifu_req_ready, a_lsu_req_ready}, 0);
    check("rst_valids", {a_mem_req_valid, a_ifu_resp_valid, a_lsu_resp_valid}, 0);
    check("rst_data", {a_mem_addr, a_ifu_rdata}, 0);

    // 1: IFU fetch, minimum latency
    rst = 1'b0; mem_req_ready = 1'b1;
    #1;
    check("t1_ifu_ready", {a_ifu_req_ready, a_lsu_req_ready}, 2'b10);
    step();
    ifu_req_valid = 1'b0;
    check("t1_issue", {a_mem_req_valid, a_mem_wen, a_mem_wmask, a_ifu_req_ready}, {1'b1, 1'b0, 4'h0, 1'b0});
    check("t1_addr", a_mem_addr, 32'h8000_0000);
    step();
    check("t1_wait", {a_busy, a_mem_req_valid, a_ifu_resp_valid}, 3'b100);
    mem_resp_valid = 1'b1; mem_rdata = 32'h0010_0093;
    step();
    mem_resp_valid = 1'b0;
    check("t1_resp", {a_ifu_resp_valid, a_lsu_resp_valid, a_ifu_resp_err}, 3'b100);
    check("t1_rdata", a_ifu_rdata, 32'h0010_0093);
    step();
    check("t1_done", {a_ifu_resp_valid, a_busy}, 0);
    check("t1_hold", a_ifu_rdata, 32'h0010_0093);

    // 2: simultaneous requests, LSU wins; IFU accepted after the LSU response
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0100; lsu_wen = 1'b0;
    #1;
    check("t2_tie", {a_lsu_req_ready, a_ifu_req_ready}, 2'b10);
    step();
    lsu_req_valid = 1'b0;
    check("t2_addr", a_mem_addr, 32'h0000_0100);
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'h1122_3344; mem_resp_err = 1'b1;
    step();
    mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
    check("t2_lsu_resp", {a_lsu_resp_valid, a_lsu_resp_err, a_ifu_resp_valid, a_ifu_req_ready}, 4'b1100);
    check("t2_lsu_rdata", a_lsu_rdata, 32'h1122_3344);
    step();
    check("t2_ifu_accept", a_ifu_req_ready, 1);
    step();
    ifu_req_valid = 1'b0;
    check("t2_ifu_addr", a_mem_addr, 32'h8000_0004);
    step();
    mem_resp_valid = 1'b1; mem_rdata = 32'haaaa_5555;
    step();
    mem_resp_valid = 1'b0;
    check("t2_ifu_resp", {a_ifu_resp_valid, a_ifu_resp_err, a_ifu_rdata}, {2'b10, 32'haaaa_5555});
    step();

    // 3: both held valid; b alternates starting with LSU, a always picks LSU
    do_reset();
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h0;
    grants = ""; last_cyc = -1; a_ifu_grants = 0;
    #1;
    for (int cyc = 0; cyc < 40 && grants.len() < 4; cyc++) begin
      if (a_ifu_req_ready) a_ifu_grants++;
      if (b_lsu_req_ready || b_ifu_req_ready) begin
        grants = {grants, b_lsu_req_ready ? "L" : "I"};
        if (last_cyc >= 0) check("t3_spacing", cyc - last_cyc, 4);
        last_cyc = cyc;
      end
      step();
    end
    check("t3_order", (grants == "LILI"), 1);
    check("t3_prio_no_ifu", a_ifu_grants, 0);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
    do_reset();

    // 4: store with memory back-pressure; fields stable, rdata forced to 0
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0200; lsu_wen = 1'b1;
    lsu_wdata = 32'hdead_beef; lsu_wmask = 4'hf; mem_req_ready = 1'b0;
    step();
    lsu_req_valid = 1'b0; lsu_wdata = 32'h0; lsu_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1'b1;
      check("t4_stable", {a_mem_req_valid, a_mem_wen, a_mem_wmask, a_mem_addr, a_mem_wdata},
            {1'b1, 1'b1, 4'hf, 32'h0000_0200, 32'hdead_beef});
      step();
    end
    mem_req_ready = 1'b0;
    check("t4_wait", a_mem_req_valid, 0);
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mem_resp_valid = 1'b0;
    check("t4_resp", {a_lsu_resp_valid, a_lsu_resp_err, a_lsu_rdata}, {2'b10, 32'h0});
    step();
    check("t4_one_pulse", a_lsu_resp_valid, 0);

    // 5: timeout after 8 WAIT cycles; late response dropped
    ifu_req_valid = 1'b1; ifu_addr = 32'h0000_0300; mem_req_ready = 1'b1;
    step();
    ifu_req_valid = 1'b0;
    step();
    for (int i = 0; i < 7; i++) begin
      step();
      check("t5_no_early", {a_ifu_resp_valid, a_busy}, 2'b01);
    end
    step();
    check("t5_timeout", {a_ifu_resp_valid, a_ifu_resp_err, a_ifu_rdata}, {2'b11, 32'h0});
    mem_resp_valid = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    check("t5_late_drop", {a_ifu_resp_valid, a_lsu_resp_valid, a_busy}, 0);
    step();
    mem_resp_valid = 1'b0;
    check("t5_idle", {a_ifu_resp_valid, a_busy, a_ifu_resp_err}, 3'b001);

    // 6: reset during WAIT aborts without a response
    lsu_req_valid = 1'b1; lsu_addr = 32'h0000_0400; lsu_wen = 1'b0;
    step();
    lsu_req_valid = 1'b0;
    step();
    check("t6_in_wait", a_busy, 1);
    rst = 1'b1;
    step();
    check("t6_abort", {a_busy, a_mem_req_valid, a_lsu_resp_valid, a_lsu_req_ready}, 0);
    rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0055;
    step();
    check("t6_no_resp", {a_lsu_resp_valid, a_ifu_resp_valid, a_busy}, 0);
    step();
    mem_resp_valid = 1'b0;
    check("t6_cleared", {a_lsu_resp_valid, a_lsu_rdata, a_mem_addr}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
